srio_nwr_packetizer: RTL and testbench
======================================

Name: srio_nwr_packetizer

Overview:
- Sits directly downstream of the UDP-to-SRIO clock-crossing stage, in the clk_srio domain.
- Consumes that stage's 64-bit frame stream: ready-request with one-cycle read latency, plus first/last/keep and frame byte length.
- Segments each frame into SRIO NWRITE packets of at most MAX_PAYLOAD bytes.
- Emits HELLO-format request packets (header beat, then data beats) on the SRIO core's AXI-Stream ireq channel.

Parameters:
- DATA_WIDTH, 64, datapath width; fixed at 64 because HELLO is 64-bit.
- SKID_DEPTH, 4, input buffer entries; must be at least 3.
- MAX_PAYLOAD, 256, maximum NWRITE payload in bytes; power of 2, at most 256.
- TTYPE_NWR, 4'h4, TTYPE placed in the header (4'h4 = NWRITE, 4'h5 = NWRITE_R).

Ports:
- clk_srio  in  1  single block clock.
- reset_srio_n  in  1  asynchronous, active-low reset.
- srio_ready_out  out  1  read request to upstream; data returns exactly one cycle later.
- nwr_req_in  in  1  frame-start indication; identical to srio_first_in.
- srio_length_in  in  16  frame length in bytes; valid when srio_first_in=1.
- srio_data_in  in  64  input beat.
- srio_valid_in  in  1  input beat valid.
- srio_first_in  in  1  first beat of frame.
- srio_keep_in  in  8  byte enables; informational only.
- srio_last_in  in  1  last beat of frame.
- base_addr_in  in  34  SRIO target byte address; sampled at frame start.
- src_id_in  in  16  source device ID.
- dest_id_in  in  16  destination device ID.
- ireq_tvalid  out  1  AXIS valid.
- ireq_tready  in  1  AXIS ready.
- ireq_tdata  out  64  header or payload.
- ireq_tkeep  out  8  always 8'hFF while tvalid=1.
- ireq_tlast  out  1  last beat of packet.
- ireq_tuser  out  32  {src_id, dest_id}, held for the whole packet.
- err_len_out  out  1  one-cycle pulse on a length/beat mismatch.
- busy_out  out  1  high while FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, skid buffer empty, TID=0. All outputs 0, except ireq_tkeep, which is 0 while tvalid=0.
- Input flow control: upstream never holds data, so every beat with srio_valid_in=1 must be absorbed.
  - pending = srio_ready_out registered one cycle.
  - srio_ready_out = (count + pending) < SKID_DEPTH (combinational).
  - Skid buffer must never overflow or drop a beat.
- Frame start: in IDLE, the buffer head carries first=1. On this beat:
  - latch rem_bytes = srio_length_in;
  - latch addr = base_addr_in;
  - latch ids.
- Input beats reaching IDLE with first=0 are popped and discarded.
- Segment size: seg = min(rem_bytes, MAX_PAYLOAD) rounded up to a multiple of 8; seg_beats = seg/8.
- HDR state: tdata =
  - [63:56] TID
  - [55:52] 4'h5
  - [51:48] TTYPE_NWR
  - [47] 0
  - [46:45] prio=2'b01
  - [44] crf=0
  - [43:36] seg-1
  - [35:34] 0
  - [33:0] addr
- HDR exit: on handshake, go to DATA.
- DATA state: ireq_tvalid = buffer non-empty; tdata = head.
  - Pop on tvalid&tready.
  - tlast on the seg_beats-th beat.
- Segment end (tlast handshake):
  - TID += 1, wrapping 255→0;
  - addr += MAX_PAYLOAD (34-bit wrap);
  - rem_bytes -= min(rem_bytes, MAX_PAYLOAD), saturating at 0.
  - If rem_bytes > 0, go to HDR; else go to IDLE if the popped beat had last=1, else DROP.
- Early last (input last=1 before the segment's final beat): emit it, then PAD. PAD emits all-zero beats until tlast completes the segment; pulse err_len_out; then IDLE.
- Late last: DROP pops buffer beats, no ireq output, until a beat with last=1 is popped; pulse err_len_out once; then IDLE.
- Zero length (srio_length_in=0 at first): no packet; frame popped via DROP; err_len_out pulse.
- First=1 seen mid-frame (in DATA): treated as early last of the current frame; that beat is not popped and starts the next frame from IDLE.
- AXIS rules: tdata/tlast/tuser stable while tvalid=1 and tready=0. tvalid never drops without a handshake, except on reset.
- Latency: header tvalid no earlier than one cycle after the first beat is in the buffer; no idle cycles between packets when data is available and tready=1.
- Reset mid-packet: output is truncated immediately; no recovery packet.

Test Plan:
- 64-byte frame, base_addr=0x1000, tready=1 -> 1 header (size=63, addr=0x1000, TID=0) + 8 data beats, tlast on beat 8, data in order.
- 600-byte frame -> 3 packets:
  - sizes 255/255/87 (88 bytes rounded), addrs 0x0/0x100/0x200, TIDs 0/1/2;
  - last packet 11 beats, final beat zero-padded bytes as received.
- Random ireq_tready (~50%) with continuous upstream streaming -> no beat lost or duplicated; skid count never exceeds 4; AXIS signals stable under backpressure.
- Length=32 but input last on beat 2 -> 2 real + 2 zero beats, err_len_out pulses once, next frame correct.
- Length=16 but 5 beats -> packet of 2 beats, 3 beats dropped, err_len_out once; length=0 -> no ireq output, err pulse.
- Reset asserted during DATA of packet TID=7 -> all outputs 0 asynchronously; next frame after release uses TID=0.

Source files
------------

// File: rtl/srio_nwr_packetizer.sv
// srio_nwr_packetizer
// Turns the 64-bit frame stream from the UDP-to-SRIO clock-crossing stage into
// HELLO-format NWRITE request packets on the SRIO core's ireq AXI-Stream channel.
// Each frame is cut into segments of at most MAX_PAYLOAD bytes. Every segment is
// sent as one header beat followed by its data beats.
//
// Ports (all in the clk_srio domain):
//   clk_srio, reset_srio_n        clock, asynchronous active-low reset
//   srio_ready_out                read request; the upstream beat arrives one cycle later
//   nwr_req_in, srio_*_in         upstream frame beat (data/valid/first/last/keep/length)
//   base_addr_in                  target byte address, sampled at frame start
//   src_id_in, dest_id_in         device IDs, sampled at frame start
//   ireq_t*                       AXI-Stream request channel to the SRIO core
//   err_len_out                   one-cycle pulse when frame length and beat count disagree
//   busy_out                      FSM is not idle
module srio_nwr_packetizer #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned SKID_DEPTH  = 4,
    parameter int unsigned MAX_PAYLOAD = 256,
    parameter logic [3:0]  TTYPE_NWR   = 4'h4
) (
    input  logic                  clk_srio,
    input  logic                  reset_srio_n,
    output logic                  srio_ready_out,
    input  logic                  nwr_req_in,
    input  logic [15:0]           srio_length_in,
    input  logic [DATA_WIDTH-1:0] srio_data_in,
    input  logic                  srio_valid_in,
    input  logic                  srio_first_in,
    input  logic [7:0]            srio_keep_in,
    input  logic                  srio_last_in,
    input  logic [33:0]           base_addr_in,
    input  logic [15:0]           src_id_in,
    input  logic [15:0]           dest_id_in,
    output logic                  ireq_tvalid,
    input  logic                  ireq_tready,
    output logic [DATA_WIDTH-1:0] ireq_tdata,
    output logic [7:0]            ireq_tkeep,
    output logic                  ireq_tlast,
    output logic [31:0]           ireq_tuser,
    output logic                  err_len_out,
    output logic                  busy_out
);

    localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(SKID_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;
    localparam logic [16:0] MaxPay = 17'(MAX_PAYLOAD);

    typedef enum logic [2:0] {StIdle, StHdr, StData, StPad, StDrop} state_e;

    // Keep bytes are informational and nwr_req duplicates first.
    logic unused_inputs;
    assign unused_inputs = ^{srio_keep_in, nwr_req_in};

    // ---------------- skid buffer ----------------
    logic [DATA_WIDTH-1:0] buf_data  [SKID_DEPTH];
    logic [15:0]           buf_len   [SKID_DEPTH];
    logic                  buf_first [SKID_DEPTH];
    logic                  buf_last  [SKID_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            pending_q;
    logic            pop;
    logic            buf_empty;
    logic [OccW-1:0] occ;

    // Upstream cannot stall, so a request is only issued if the beat it returns
    // is guaranteed a free slot, counting the beat already in flight.
    always_comb begin
        occ            = OccW'(count_q) + OccW'(pending_q);
        srio_ready_out = occ < OccW'(SKID_DEPTH);
    end

    assign buf_empty = (count_q == '0);

    always_ff @(posedge clk_srio) begin
        if (srio_valid_in) begin
            buf_data[wr_ptr_q]  <= srio_data_in;
            buf_len[wr_ptr_q]   <= srio_length_in;
            buf_first[wr_ptr_q] <= srio_first_in;
            buf_last[wr_ptr_q]  <= srio_last_in;
        end
    end

    always_ff @(posedge clk_srio or negedge reset_srio_n) begin
        if (!reset_srio_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            pending_q <= srio_ready_out;
            if (srio_valid_in) begin
                wr_ptr_q <= (wr_ptr_q == PtrW'(SKID_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(SKID_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
            end
            case ({srio_valid_in, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] head_data;
    logic [15:0]           head_len;
    logic                  head_first, head_last;
    assign head_data  = buf_data[rd_ptr_q];
    assign head_len   = buf_len[rd_ptr_q];
    assign head_first = buf_first[rd_ptr_q];
    assign head_last  = buf_last[rd_ptr_q];

    // ---------------- packetizer FSM ----------------
    state_e      state_q, state_d;
    logic [7:0]  tid_q, tid_d;
    logic [33:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic [31:0] ids_q, ids_d;
    logic [5:0]  beat_q, beat_d;
    logic        frame_start_q, frame_start_d;  // the current head is this frame's first beat
    logic        err_q, err_d;

    logic [16:0] seg_min, seg_bytes;
    logic [7:0]  seg_len_m1;
    logic [5:0]  seg_beats;
    logic        last_beat;
    logic [15:0] rem_next;

    always_comb begin
        seg_min    = ({1'b0, rem_q} > MaxPay) ? MaxPay : {1'b0, rem_q};
        seg_bytes  = (seg_min + 17'd7) & 17'h1FFF8;
        seg_len_m1 = 8'(seg_bytes - 17'd1);
        seg_beats  = 6'(seg_bytes >> 3);
        last_beat  = (beat_q == seg_beats - 6'd1);
        rem_next   = rem_q - 16'(seg_min);
    end

    always_ff @(posedge clk_srio or negedge reset_srio_n) begin
        if (!reset_srio_n) begin
            state_q       <= StIdle;
            tid_q         <= '0;
            addr_q        <= '0;
            rem_q         <= '0;
            ids_q         <= '0;
            beat_q        <= '0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            tid_q         <= tid_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            ids_q         <= ids_d;
            beat_q        <= beat_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tid_d         = tid_q;
        addr_d        = addr_q;
        rem_d         = rem_q;
        ids_d         = ids_q;
        beat_d        = beat_q;
        frame_start_d = frame_start_q;
        err_d         = 1'b0;
        pop           = 1'b0;
        ireq_tvalid   = 1'b0;
        ireq_tdata    = '0;
        ireq_tlast    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!buf_empty) begin
                    if (head_first) begin
                        rem_d         = head_len;
                        addr_d        = base_addr_in;
                        ids_d         = {src_id_in, dest_id_in};
                        beat_d        = '0;
                        frame_start_d = 1'b1;
                        state_d       = (head_len == 16'd0) ? StDrop : StHdr;
                    end else begin
                        pop = 1'b1;  // orphan beat with no frame start
                    end
                end
            end
            StHdr: begin
                ireq_tvalid = 1'b1;
                ireq_tdata  = DATA_WIDTH'({tid_q, 4'h5, TTYPE_NWR, 1'b0, 2'b01, 1'b0,
                                           seg_len_m1, 2'b00, addr_q});
                if (ireq_tready) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (!buf_empty) begin
                    if (head_first && !frame_start_q) begin
                        // Next frame started early: finish this segment with padding
                        // and leave the new first beat for IDLE.
                        state_d = StPad;
                    end else begin
                        ireq_tvalid = 1'b1;
                        ireq_tdata  = head_data;
                        ireq_tlast  = last_beat;
                        if (ireq_tready) begin
                            pop           = 1'b1;
                            frame_start_d = 1'b0;
                            beat_d        = beat_q + 6'd1;
                            if (last_beat) begin
                                beat_d = '0;
                                tid_d  = tid_q + 8'd1;
                                addr_d = addr_q + 34'(MAX_PAYLOAD);
                                rem_d  = rem_next;
                                if (rem_next != 16'd0) begin
                                    // Frame ended on a segment boundary but length says more.
                                    if (head_last) begin
                                        state_d = StIdle;
                                        err_d   = 1'b1;
                                    end else begin
                                        state_d = StHdr;
                                    end
                                end else begin
                                    state_d = head_last ? StIdle : StDrop;
                                end
                            end else if (head_last) begin
                                state_d = StPad;
                            end
                        end
                    end
                end
            end
            StPad: begin
                ireq_tvalid = 1'b1;
                ireq_tlast  = last_beat;
                if (ireq_tready) begin
                    beat_d = beat_q + 6'd1;
                    if (last_beat) begin
                        beat_d  = '0;
                        tid_d   = tid_q + 8'd1;
                        addr_d  = addr_q + 34'(MAX_PAYLOAD);
                        rem_d   = '0;
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end
            end
            StDrop: begin
                if (!buf_empty) begin
                    if (head_first && !frame_start_q) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end else begin
                        pop           = 1'b1;
                        frame_start_d = 1'b0;
                        if (head_last) begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ireq_tkeep  = ireq_tvalid ? 8'hFF : 8'h00;
    assign ireq_tuser  = ids_q;
    assign err_len_out = err_q;
    assign busy_out    = (state_q != StIdle);

endmodule

// File: tb/tb_srio_nwr_packetizer.sv
// Scoreboard bench for srio_nwr_packetizer: stimulus tasks push upstream beats and
// the expected ireq beats; an upstream model answers read requests one cycle later
// and a monitor compares every ireq handshake against the expected queue.
module tb_srio_nwr_packetizer;

    logic        clk_srio = 1'b0;
    logic        reset_srio_n;
    logic        srio_ready_out;
    logic        nwr_req_in;
    logic [15:0] srio_length_in;
    logic [63:0] srio_data_in;
    logic        srio_valid_in;
    logic        srio_first_in;
    logic [7:0]  srio_keep_in;
    logic        srio_last_in;
    logic [33:0] base_addr_in;
    logic [15:0] src_id_in;
    logic [15:0] dest_id_in;
    logic        ireq_tvalid;
    logic        ireq_tready;
    logic [63:0] ireq_tdata;
    logic [7:0]  ireq_tkeep;
    logic        ireq_tlast;
    logic [31:0] ireq_tuser;
    logic        err_len_out;
    logic        busy_out;

    always #5 clk_srio = ~clk_srio;

    srio_nwr_packetizer dut (
        .clk_srio       (clk_srio),
        .reset_srio_n   (reset_srio_n),
        .srio_ready_out (srio_ready_out),
        .nwr_req_in     (nwr_req_in),
        .srio_length_in (srio_length_in),
        .srio_data_in   (srio_data_in),
        .srio_valid_in  (srio_valid_in),
        .srio_first_in  (srio_first_in),
        .srio_keep_in   (srio_keep_in),
        .srio_last_in   (srio_last_in),
        .base_addr_in   (base_addr_in),
        .src_id_in      (src_id_in),
        .dest_id_in     (dest_id_in),
        .ireq_tvalid    (ireq_tvalid),
        .ireq_tready    (ireq_tready),
        .ireq_tdata     (ireq_tdata),
        .ireq_tkeep     (ireq_tkeep),
        .ireq_tlast     (ireq_tlast),
        .ireq_tuser     (ireq_tuser),
        .err_len_out    (err_len_out),
        .busy_out       (busy_out)
    );

    typedef struct packed {
        logic [63:0] data;
        logic        first;
        logic        last;
        logic [15:0] len;
    } beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic [31:0] user;
    } exp_t;

    beat_t      in_q[$];
    exp_t       exp_q[$];
    int         checks = 0;
    int         passes = 0;
    int         err_seen = 0;
    int         err_exp = 0;
    logic [7:0] tid_m = 8'd0;
    bit         rnd_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] tid, input logic [7:0] sm1,
                                        input logic [33:0] a);
        return {tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, sm1, 2'b00, a};
    endfunction

    // Upstream: a request seen in cycle t is answered with a beat in cycle t+1.
    initial begin
        bit    req;
        beat_t b;
        srio_valid_in  = 1'b0;
        srio_data_in   = '0;
        srio_first_in  = 1'b0;
        srio_last_in   = 1'b0;
        srio_length_in = '0;
        nwr_req_in     = 1'b0;
        srio_keep_in   = 8'hFF;
        forever begin
            @(negedge clk_srio);
            req = srio_ready_out && reset_srio_n && (in_q.size() > 0);
            @(posedge clk_srio);
            #1;
            if (req && in_q.size() > 0) begin
                b              = in_q.pop_front();
                srio_data_in   = b.data;
                srio_first_in  = b.first;
                nwr_req_in     = b.first;
                srio_last_in   = b.last;
                srio_length_in = b.len;
                srio_valid_in  = 1'b1;
            end else begin
                srio_valid_in = 1'b0;
            end
        end
    end

    initial begin
        ireq_tready = 1'b1;
        forever begin
            @(posedge clk_srio);
            #1;
            ireq_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes against the scoreboard, hold-under-backpressure rules.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    logic [31:0] prev_user;
    exp_t        mon_e;
    always @(negedge clk_srio) begin
        if (!reset_srio_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_tvalid", 64'(ireq_tvalid), 64'd1);
                chk("hold_tdata", ireq_tdata, prev_data);
                chk("hold_tlast", 64'(ireq_tlast), 64'(prev_last));
                chk("hold_tuser", 64'(ireq_tuser), 64'(prev_user));
            end
            if (ireq_tvalid) chk("tkeep", 64'(ireq_tkeep), 64'hFF);
            if (ireq_tvalid && ireq_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", ireq_tdata, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("tdata", ireq_tdata, mon_e.data);
                    chk("tlast", 64'(ireq_tlast), 64'(mon_e.last));
                    chk("tuser", 64'(ireq_tuser), 64'(mon_e.user));
                end
            end
            if (err_len_out) err_seen++;
            prev_stall = ireq_tvalid && !ireq_tready;
            prev_data  = ireq_tdata;
            prev_last  = ireq_tlast;
            prev_user  = ireq_tuser;
        end
    end

    // Queue a frame of nb beats declaring len bytes, plus the ireq beats it must produce.
    task automatic add_frame(input int len, input int nb, input logic [31:0] seed);
        logic [63:0] d[$];
        logic [33:0] a;
        logic [63:0] dv;
        logic [31:0] user;
        int          rem, k, smin, sb;
        bit          pad;
        beat_t       b;
        user = {src_id_in, dest_id_in};
        for (int i = 0; i < nb; i++) begin
            d.push_back({seed, 32'(i)});
            b.data  = {seed, 32'(i)};
            b.first = (i == 0);
            b.last  = (i == nb - 1);
            b.len   = (i == 0) ? 16'(len) : 16'hFFFF;
            in_q.push_back(b);
        end
        rem = len;
        k   = 0;
        pad = 1'b0;
        a   = base_addr_in;
        while (rem > 0 && !pad) begin
            smin = (rem < 256) ? rem : 256;
            sb   = (smin + 7) / 8;
            exp_q.push_back({hdr(tid_m, 8'(sb * 8 - 1), a), 1'b0, user});
            for (int j = 0; j < sb; j++) begin
                if (!pad && k < nb) begin
                    dv = d[k];
                    if (k == nb - 1 && j != sb - 1) pad = 1'b1;
                    k++;
                end else begin
                    dv = '0;
                end
                exp_q.push_back({dv, (j == sb - 1), user});
            end
            tid_m++;
            a   = a + 34'd256;
            rem = rem - smin;
        end
        if (len == 0 || pad || k < nb) err_exp++;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk_srio);
            if (in_q.size() == 0 && exp_q.size() == 0 && !busy_out && !srio_valid_in) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (10) @(negedge clk_srio);
        chk({name, "_drained"}, 64'(ok), 64'd1);
        chk({name, "_err_pulses"}, 64'(err_seen), 64'(err_exp));
        if (!ok) begin
            in_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic reset_dut();
        @(negedge clk_srio);
        reset_srio_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk_srio);
        reset_srio_n = 1'b1;
        tid_m = 8'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n0;
        bit ok;
        reset_srio_n = 1'b0;
        base_addr_in = 34'h1000;
        src_id_in    = 16'h00A1;
        dest_id_in   = 16'h00B2;
        repeat (3) @(negedge clk_srio);
        chk("rst_tvalid", 64'(ireq_tvalid), 64'd0);
        chk("rst_tkeep", 64'(ireq_tkeep), 64'd0);
        chk("rst_tdata", ireq_tdata, 64'd0);
        chk("rst_tlast", 64'(ireq_tlast), 64'd0);
        chk("rst_tuser", 64'(ireq_tuser), 64'd0);
        chk("rst_err", 64'(err_len_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        reset_srio_n = 1'b1;

        // 64-byte frame at 0x1000: header written out by hand.
        for (int i = 0; i < 8; i++) begin
            in_q.push_back({{32'h0000_A000, 32'(i)}, (i == 0), (i == 7),
                            (i == 0) ? 16'd64 : 16'hFFFF});
        end
        exp_q.push_back({64'h0054_23F0_0000_1000, 1'b0, 32'h00A1_00B2});
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({{32'h0000_A000, 32'(i)}, (i == 7), 32'h00A1_00B2});
        end
        tid_m = 8'd1;
        wait_done("frame64");

        // 600-byte frame: three packets of 255/255/87, TIDs 0/1/2.
        reset_dut();
        base_addr_in = 34'h0;
        src_id_in    = 16'h1234;
        dest_id_in   = 16'h5678;
        add_frame(600, 75, 32'hB600_0000);
        wait_done("frame600");

        // Back-to-back frames under random backpressure.
        rnd_ready = 1'b1;
        base_addr_in = 34'h3_FFFF_FF00;  // address wraps on the second segment
        add_frame(600, 75, 32'hC000_0001);
        add_frame(64, 8, 32'hC000_0002);
        add_frame(40, 5, 32'hC000_0003);
        wait_done("random_ready");
        rnd_ready = 1'b0;

        // Early last: 32 bytes declared, 2 beats delivered; then a clean frame.
        base_addr_in = 34'h2000;
        add_frame(32, 2, 32'hD000_0001);
        add_frame(64, 8, 32'hD000_0002);
        wait_done("early_last");

        // Late last (16 bytes, 5 beats), zero length, then a clean frame.
        add_frame(16, 5, 32'hE000_0001);
        add_frame(0, 1, 32'hE000_0002);
        add_frame(24, 3, 32'hE000_0003);
        wait_done("late_last_zero");

        // Reset during the data phase of the TID=7 packet.
        reset_dut();
        base_addr_in = 34'h4000;
        add_frame(600, 75, 32'hF000_0001);
        add_frame(600, 75, 32'hF000_0002);
        add_frame(64, 8, 32'hF000_0003);
        wait_done("pre_reset");
        add_frame(600, 75, 32'hF000_0004);
        n0 = exp_q.size();
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_srio);
            if (exp_q.size() <= n0 - 4) begin
                ok = 1'b1;
                break;
            end
        end
        chk("tid7_progress", 64'(ok), 64'd1);
        #2;
        reset_srio_n = 1'b0;
        in_q.delete();
        exp_q.delete();
        #1;
        chk("async_tvalid", 64'(ireq_tvalid), 64'd0);
        chk("async_tdata", ireq_tdata, 64'd0);
        chk("async_tkeep", 64'(ireq_tkeep), 64'd0);
        chk("async_tuser", 64'(ireq_tuser), 64'd0);
        chk("async_busy", 64'(busy_out), 64'd0);
        repeat (3) @(negedge clk_srio);
        reset_srio_n = 1'b1;
        tid_m = 8'd0;
        add_frame(64, 8, 32'hF000_0005);
        wait_done("post_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
